byte_to_lane_mapper: RTL and testbench

Transmit-side mainband mapper: accepts one 512-bit flit per valid/ready handshake and distributes it over 16 × 32-bit TX lanes. In full-width mode (lanes 0–15) a flit is sent in one beat. In degraded modes (lanes 0–7 or lanes 8–15) it is sent in two beats. Sits between the TX flit source and the per-lane serializers. Its byte ordering is the exact inverse of the RX lane-to-byte demapper, so a loopback returns the original 512-bit word.

---
 rtl/byte_to_lane_mapper.sv | 159 +++++++++++++++
 tb/tb_byte_to_lane_mapper.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_to_lane_mapper.sv
// Transmit mainband mapper: splits one 512-bit flit over 16 x 32-bit TX lanes,
// one beat in full-width mode or two beats when only half the lanes are usable.
module byte_to_lane_mapper #(
  parameter int WIDTH     = 32,
  parameter int N_BYTES   = 64,
  parameter int NUM_LANES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable_mapper,
  input  logic [1:0]             i_functional_tx_lanes,
  input  logic [8*N_BYTES-1:0]   i_data,
  input  logic                   i_data_valid,
  output logic                   o_data_ready,
  output logic [WIDTH-1:0]       o_lane_0,
  output logic [WIDTH-1:0]       o_lane_1,
  output logic [WIDTH-1:0]       o_lane_2,
  output logic [WIDTH-1:0]       o_lane_3,
  output logic [WIDTH-1:0]       o_lane_4,
  output logic [WIDTH-1:0]       o_lane_5,
  output logic [WIDTH-1:0]       o_lane_6,
  output logic [WIDTH-1:0]       o_lane_7,
  output logic [WIDTH-1:0]       o_lane_8,
  output logic [WIDTH-1:0]       o_lane_9,
  output logic [WIDTH-1:0]       o_lane_10,
  output logic [WIDTH-1:0]       o_lane_11,
  output logic [WIDTH-1:0]       o_lane_12,
  output logic [WIDTH-1:0]       o_lane_13,
  output logic [WIDTH-1:0]       o_lane_14,
  output logic [WIDTH-1:0]       o_lane_15,
  output logic                   o_lane_valid,
  output logic                   o_last_beat,
  output logic                   o_dbg_state,
  output logic                   o_dbg_beat
);

  localparam int DATA_BITS = 8 * N_BYTES;
  localparam int HALF      = NUM_LANES / 2;
  localparam int BEAT_BITS = HALF * WIDTH;
  localparam int LANE_BITS = NUM_LANES * WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic                 beat_q, beat_d;
  logic [1:0]           mode_q, mode_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [LANE_BITS-1:0] lanes_q, lanes_d;
  logic                 lane_valid_q, lane_valid_d;
  logic                 last_beat_q, last_beat_d;
  logic                 accept;

  // Handshake: a flit moves when i_data_valid and o_data_ready are both high
  // at a rising edge; ready never depends on valid.
  assign o_data_ready = i_rst_n & i_enable_mapper & (i_functional_tx_lanes != 2'b00)
                      & ((state_q == IDLE) | last_beat_q);
  assign accept = i_data_valid & o_data_ready;

  function automatic logic last_idx(input logic [1:0] mode);
    return (mode == 2'b11) ? 1'b0 : 1'b1;
  endfunction

  // Half-width modes take 256-bit slices: beat b carries data[b*256 +: 256].
  function automatic logic [LANE_BITS-1:0] map_beat(input logic [DATA_BITS-1:0] data,
                                                    input logic [1:0] mode,
                                                    input logic beat);
    logic [LANE_BITS-1:0] lanes;
    int                   base;
    lanes = '0;
    base  = beat ? BEAT_BITS : 0;
    for (int k = 0; k < HALF; k++) begin
      case (mode)
        2'b11: begin
          lanes[k*WIDTH +: WIDTH]        = data[k*WIDTH +: WIDTH];
          lanes[(k+HALF)*WIDTH +: WIDTH] = data[(k+HALF)*WIDTH +: WIDTH];
        end
        2'b01:   lanes[k*WIDTH +: WIDTH]        = data[base + k*WIDTH +: WIDTH];
        2'b10:   lanes[(k+HALF)*WIDTH +: WIDTH] = data[base + k*WIDTH +: WIDTH];
        default: ;
      endcase
    end
    return lanes;
  endfunction

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    mode_d       = mode_q;
    hold_d       = hold_q;
    lanes_d      = lanes_q;
    lane_valid_d = lane_valid_q;
    if (!i_enable_mapper) begin
      state_d      = IDLE;
      beat_d       = 1'b0;
      lanes_d      = '0;
      lane_valid_d = 1'b0;
    end else if (accept) begin
      state_d      = SEND;
      beat_d       = 1'b0;
      mode_d       = i_functional_tx_lanes;
      hold_d       = i_data;
      lanes_d      = map_beat(i_data, i_functional_tx_lanes, 1'b0);
      lane_valid_d = 1'b1;
    end else if (state_q == SEND && !last_beat_q) begin
      // Later beats come only from the holding register, never from i_data.
      beat_d  = beat_q + 1'b1;
      lanes_d = map_beat(hold_q, mode_q, beat_d);
    end else begin
      state_d      = IDLE;
      beat_d       = 1'b0;
      lanes_d      = '0;
      lane_valid_d = 1'b0;
    end
    last_beat_d = lane_valid_d & (beat_d == last_idx(mode_d));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      beat_q       <= 1'b0;
      mode_q       <= 2'b00;
      hold_q       <= '0;
      lanes_q      <= '0;
      lane_valid_q <= 1'b0;
      last_beat_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      mode_q       <= mode_d;
      hold_q       <= hold_d;
      lanes_q      <= lanes_d;
      lane_valid_q <= lane_valid_d;
      last_beat_q  <= last_beat_d;
    end
  end

  assign o_lane_valid = lane_valid_q;
  assign o_last_beat  = last_beat_q;
  assign o_dbg_state  = (state_q == SEND);
  assign o_dbg_beat   = beat_q;

  assign o_lane_0  = lanes_q[0*WIDTH +: WIDTH];
  assign o_lane_1  = lanes_q[1*WIDTH +: WIDTH];
  assign o_lane_2  = lanes_q[2*WIDTH +: WIDTH];
  assign o_lane_3  = lanes_q[3*WIDTH +: WIDTH];
  assign o_lane_4  = lanes_q[4*WIDTH +: WIDTH];
  assign o_lane_5  = lanes_q[5*WIDTH +: WIDTH];
  assign o_lane_6  = lanes_q[6*WIDTH +: WIDTH];
  assign o_lane_7  = lanes_q[7*WIDTH +: WIDTH];
  assign o_lane_8  = lanes_q[8*WIDTH +: WIDTH];
  assign o_lane_9  = lanes_q[9*WIDTH +: WIDTH];
  assign o_lane_10 = lanes_q[10*WIDTH +: WIDTH];
  assign o_lane_11 = lanes_q[11*WIDTH +: WIDTH];
  assign o_lane_12 = lanes_q[12*WIDTH +: WIDTH];
  assign o_lane_13 = lanes_q[13*WIDTH +: WIDTH];
  assign o_lane_14 = lanes_q[14*WIDTH +: WIDTH];
  assign o_lane_15 = lanes_q[15*WIDTH +: WIDTH];

endmodule

// File: tb/tb_byte_to_lane_mapper.sv
// Bench for byte_to_lane_mapper: directed scenarios plus random traffic,
// checked against a beat-queue reference model built from the lane mapping rules.
module tb_byte_to_lane_mapper;

  localparam int WIDTH     = 32;
  localparam int N_BYTES   = 64;
  localparam int NUM_LANES = 16;
  localparam int DW        = 8 * N_BYTES;
  localparam int LW        = NUM_LANES * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [DW-1:0]    data;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] lane [NUM_LANES];
  logic             lane_valid;
  logic             last_beat;
  logic             dbg_state;
  logic             dbg_beat;
  logic [LW-1:0]    lanes_obs;

  int checks = 0;
  int errors = 0;

  // Reference model: pending beats of the current flit, MSB = last-beat flag.
  logic [LW:0]   exp_q[$];
  logic          m_valid = 1'b0;
  logic          m_last  = 1'b0;
  logic [LW-1:0] m_lanes = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  byte_to_lane_mapper #(.WIDTH(WIDTH), .N_BYTES(N_BYTES), .NUM_LANES(NUM_LANES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable_mapper(en),
    .i_functional_tx_lanes(mode), .i_data(data), .i_data_valid(valid),
    .o_data_ready(ready),
    .o_lane_0(lane[0]),   .o_lane_1(lane[1]),   .o_lane_2(lane[2]),   .o_lane_3(lane[3]),
    .o_lane_4(lane[4]),   .o_lane_5(lane[5]),   .o_lane_6(lane[6]),   .o_lane_7(lane[7]),
    .o_lane_8(lane[8]),   .o_lane_9(lane[9]),   .o_lane_10(lane[10]), .o_lane_11(lane[11]),
    .o_lane_12(lane[12]), .o_lane_13(lane[13]), .o_lane_14(lane[14]), .o_lane_15(lane[15]),
    .o_lane_valid(lane_valid), .o_last_beat(last_beat),
    .o_dbg_state(dbg_state), .o_dbg_beat(dbg_beat)
  );

  assign lanes_obs = {lane[15], lane[14], lane[13], lane[12], lane[11], lane[10], lane[9], lane[8],
                      lane[7], lane[6], lane[5], lane[4], lane[3], lane[2], lane[1], lane[0]};

  // ---------------- reference model ----------------
  function automatic logic [LW-1:0] ref_beat(input logic [DW-1:0] d, input logic [1:0] md, input int b);
    logic [LW-1:0] r;
    int src;
    r = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      src = -1;
      if (md == 2'b11) src = k;
      else if (md == 2'b01 && k < 8) src = b * 8 + k;
      else if (md == 2'b10 && k >= 8) src = b * 8 + (k - 8);
      if (src >= 0) r[k*WIDTH +: WIDTH] = d[src*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic m_ready();
    return rst_n & en & (mode != 2'b00) & (!m_valid | m_last);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_lanes = '0;
  endtask

  // ---------------- driver ----------------
  // Advance one clock edge, update the model from the inputs seen at that edge.
  task automatic cycle();
    logic acc;
    logic [LW:0] e;
    int nb;
    acc = valid & m_ready();
    @(posedge clk);
    if (!en) begin
      exp_q.delete();
    end else if (acc) begin
      exp_q.delete();
      nb = (mode == 2'b11) ? 1 : 2;
      for (int b = 0; b < nb; b++) exp_q.push_back({1'(b == nb - 1), ref_beat(data, mode, b)});
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_valid = 1'b1;
      m_last  = e[LW];
      m_lanes = e[LW-1:0];
    end else begin
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_lanes = '0;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'b11; valid = 1'b1; data = rand_data();
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready, lane_valid, last_beat, lanes_obs} !== {(LW+3){1'b0}}) begin
        errors++;
        $display("FAIL reset step %0d rdy/val/last got %b%b%b lanes %h exp all 0", i, ready, lane_valid, last_beat, lanes_obs);
      end
    end
    rst_n = 1'b1; valid = 1'b0;
  endtask

  task automatic test_mode11_single();
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = {4{8'(k)}};
    mode = 2'b11; data = d; valid = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL m11_single ready got %b exp 1", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {2'b11, d}) begin
      errors++;
      $display("FAIL m11_single beat got v%b l%b %h exp v1 l1 %h", lane_valid, last_beat, lanes_obs, d);
    end
    valid = 1'b0; data = rand_data();
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {(LW+2){1'b0}}) begin
      errors++;
      $display("FAIL m11_single idle got v%b l%b %h exp 0", lane_valid, last_beat, lanes_obs);
    end
  endtask

  task automatic test_mode01();
    logic [255:0] a, b;
    a = rand_data(); b = rand_data();
    mode = 2'b01; data = {b, a}; valid = 1'b1;
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes} || lanes_obs !== {256'd0, a}) begin
      errors++;
      $display("FAIL m01_beat0 got v%b l%b %h exp v1 l0 %h", lane_valid, last_beat, lanes_obs, {256'd0, a});
    end
    valid = 1'b0; data = rand_data();
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL m01_beat0_ready got %b exp 0", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {2'b11, 256'd0, b}) begin
      errors++;
      $display("FAIL m01_beat1 got v%b l%b %h exp v1 l1 %h", lane_valid, last_beat, lanes_obs, {256'd0, b});
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL m01_beat1_ready got %b exp 1", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes}) begin
      errors++;
      $display("FAIL m01_idle got v%b l%b %h exp v%b l%b %h", lane_valid, last_beat, lanes_obs, m_valid, m_last, m_lanes);
    end
  endtask

  task automatic test_mode10_stream();
    int acc_cnt;
    logic acc;
    acc_cnt = 0;
    mode = 2'b10; valid = 1'b1; data = rand_data();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ready !== m_ready() || (i <= 6 && ready !== 1'(i % 2 == 0))) begin
        errors++;
        $display("FAIL m10_stream_ready step %0d got %b exp %b", i, ready, m_ready());
      end
      acc = valid & m_ready();
      cycle();
      checks++;
      if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes} ||
          lane_valid !== 1'(i <= 5) || lanes_obs[255:0] !== 256'd0) begin
        errors++;
        $display("FAIL m10_stream step %0d got v%b l%b %h exp v%b l%b %h", i, lane_valid, last_beat, lanes_obs, m_valid, m_last, m_lanes);
      end
      if (acc) begin
        acc_cnt++;
        data = rand_data();
      end
      if (acc_cnt == 3) valid = 1'b0;
    end
  endtask

  task automatic test_mode11_stream();
    mode = 2'b11; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) valid = 1'b0;
      data = rand_data();
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL m11_stream_ready step %0d got %b exp 1", i, ready); end
      cycle();
      checks++;
      if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes} || last_beat !== 1'(i < 4)) begin
        errors++;
        $display("FAIL m11_stream step %0d got v%b l%b %h exp v%b l%b %h", i, lane_valid, last_beat, lanes_obs, m_valid, m_last, m_lanes);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [DW-1:0] c;
    mode = 2'b01; valid = 1'b1; data = rand_data();
    cycle();
    c = rand_data();
    mode = 2'b11; data = c;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL switch_beat0_ready got %b exp 0", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes} || lanes_obs[511:256] !== 256'd0) begin
      errors++;
      $display("FAIL switch_beat1 got v%b l%b %h exp v%b l%b %h", lane_valid, last_beat, lanes_obs, m_valid, m_last, m_lanes);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL switch_beat1_ready got %b exp 1", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {2'b11, c}) begin
      errors++;
      $display("FAIL switch_full got v%b l%b %h exp v1 l1 %h", lane_valid, last_beat, lanes_obs, c);
    end
    valid = 1'b0;
    cycle();
  endtask

  task automatic test_enable_drop();
    mode = 2'b01; valid = 1'b1; data = rand_data();
    cycle();
    en = 1'b0; data = rand_data();
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL en_drop_ready got %b exp 0", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {(LW+2){1'b0}}) begin
      errors++;
      $display("FAIL en_drop_flush got v%b l%b %h exp 0", lane_valid, last_beat, lanes_obs);
    end
    en = 1'b1; data = rand_data();
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL en_restore_ready got %b exp 1", ready); end
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes} || {lane_valid, last_beat} !== 2'b10) begin
      errors++;
      $display("FAIL en_restart_beat0 got v%b l%b %h exp v1 l0 %h", lane_valid, last_beat, lanes_obs, m_lanes);
    end
    valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_async_reset();
    mode = 2'b01; valid = 1'b1; data = rand_data();
    cycle();
    valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({ready, lane_valid, last_beat, lanes_obs} !== {(LW+3){1'b0}}) begin
      errors++;
      $display("FAIL async_reset got r%b v%b l%b %h exp 0", ready, lane_valid, last_beat, lanes_obs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({lane_valid, last_beat, lanes_obs} !== {(LW+2){1'b0}}) begin
      errors++;
      $display("FAIL async_reset_release got v%b l%b %h exp 0", lane_valid, last_beat, lanes_obs);
    end
  endtask

  task automatic test_mode00();
    mode = 2'b00; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = rand_data();
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL m00_ready step %0d got %b exp 0", i, ready); end
      cycle();
      checks++;
      if ({lane_valid, last_beat, lanes_obs} !== {(LW+2){1'b0}}) begin
        errors++;
        $display("FAIL m00_lanes step %0d got v%b l%b %h exp 0", i, lane_valid, last_beat, lanes_obs);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      mode  = 2'($urandom_range(0, 3));
      valid = 1'($urandom_range(0, 1));
      data  = rand_data();
      #1;
      checks++;
      if (ready !== m_ready()) begin errors++; $display("FAIL rand_ready step %0d got %b exp %b", i, ready, m_ready()); end
      cycle();
      checks++;
      if ({lane_valid, last_beat, lanes_obs} !== {m_valid, m_last, m_lanes}) begin
        errors++;
        $display("FAIL rand_out step %0d got v%b l%b %h exp v%b l%b %h", i, lane_valid, last_beat, lanes_obs, m_valid, m_last, m_lanes);
      end
    end
    en = 1'b1; valid = 1'b0;
    cycle();
    cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mode11_single();
    test_mode01();
    test_mode10_stream();
    test_mode11_stream();
    test_mode_switch();
    test_enable_drop();
    test_async_reset();
    test_mode00();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
